// File: rtl/clk_gen_pkg.sv
// Shared encodings and helpers for the clock-source divider blocks.
package clk_gen_pkg;

  localparam logic MODE_INT  = 1'b0;
  localparam logic MODE_POW2 = 1'b1;

  localparam int unsigned MIN_DIV = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } div_state_t;

  // Power-of-two exponent limited to [1, max_k] so the period stays within 2..2^max_k.
  function automatic int unsigned clamp_exp(input int unsigned k, input int unsigned max_k);
    int unsigned r;
    r = k;
    if (r < 1) r = 1;
    if (r > max_k) r = max_k;
    return r;
  endfunction

endpackage

// File: rtl/div_cfg_decode.sv
// Maps a divide configuration (mode, value) to period-minus-one and high-phase-minus-one.
module div_cfg_decode
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             mode,
  input  logic [DIV_W-1:0] val,
  output logic [DIV_W-1:0] pm1,
  output logic [DIV_W-1:0] hm1
);

  localparam int unsigned PW = DIV_W + 1;

  logic [PW-1:0] period;

  // One extra bit holds 2^DIV_W; odd periods give the high phase the extra cycle.
  always_comb begin
    period = PW'(MIN_DIV);
    if (mode == MODE_POW2) begin
      period = PW'(1) << clamp_exp(32'(val), DIV_W);
    end else if (PW'(val) >= PW'(MIN_DIV)) begin
      period = PW'(val);
    end
    pm1 = DIV_W'(period - PW'(1));
    hm1 = DIV_W'(((period + PW'(1)) >> 1) - PW'(1));
  end

endmodule

// File: rtl/prog_clk_divider.sv
// Programmable clock divider: registered divided clock plus period tick, with
// divisor changes and start/stop confined to period boundaries.
module prog_clk_divider
  import clk_gen_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_wr,
  input  logic             div_mode,
  input  logic [DIV_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic             cfg_pending,
  output logic             cfg_applied
);

  localparam logic [DIV_W-1:0] RST_PM1 = DIV_W'(DEFAULT_DIV - 1);
  localparam logic [DIV_W-1:0] RST_HM1 = DIV_W'((DEFAULT_DIV + 1) / 2 - 1);

  div_state_t       state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] act_pm1, act_pm1_nxt;
  logic [DIV_W-1:0] act_hm1, act_hm1_nxt;
  logic             pend_mode, pend_mode_nxt;
  logic [DIV_W-1:0] pend_val, pend_val_nxt;
  logic [DIV_W-1:0] pend_pm1, pend_hm1;
  logic             clk_out_nxt, tick_nxt, running_nxt;
  logic             cfg_pending_nxt, cfg_applied_nxt;
  logic             boundary, apply_cfg;

  div_cfg_decode #(
    .DIV_W(DIV_W)
  ) u_decode (
    .mode(pend_mode),
    .val (pend_val),
    .pm1 (pend_pm1),
    .hm1 (pend_hm1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      act_pm1     <= RST_PM1;
      act_hm1     <= RST_HM1;
      pend_mode   <= MODE_INT;
      pend_val    <= '0;
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      running     <= 1'b0;
      cfg_pending <= 1'b0;
      cfg_applied <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      act_pm1     <= act_pm1_nxt;
      act_hm1     <= act_hm1_nxt;
      pend_mode   <= pend_mode_nxt;
      pend_val    <= pend_val_nxt;
      clk_out     <= clk_out_nxt;
      tick        <= tick_nxt;
      running     <= running_nxt;
      cfg_pending <= cfg_pending_nxt;
      cfg_applied <= cfg_applied_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    act_pm1_nxt     = act_pm1;
    act_hm1_nxt     = act_hm1;
    pend_mode_nxt   = pend_mode;
    pend_val_nxt    = pend_val;
    clk_out_nxt     = clk_out;
    tick_nxt        = 1'b0;
    cfg_pending_nxt = cfg_pending;
    cfg_applied_nxt = 1'b0;

    boundary  = (state == ST_RUN) && (cnt == act_pm1);
    apply_cfg = cfg_pending && ((state == ST_IDLE) || boundary);

    // A pending value takes effect for the period that starts on this edge.
    if (apply_cfg) begin
      act_pm1_nxt     = pend_pm1;
      act_hm1_nxt     = pend_hm1;
      cfg_pending_nxt = 1'b0;
      cfg_applied_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (en) begin
          state_nxt   = ST_RUN;
          cnt_nxt     = '0;
          clk_out_nxt = 1'b1;
          tick_nxt    = 1'b1;
        end
      end
      ST_RUN: begin
        if (boundary) begin
          cnt_nxt = '0;
          if (en) begin
            clk_out_nxt = 1'b1;
            tick_nxt    = 1'b1;
          end else begin
            state_nxt   = ST_IDLE;
            clk_out_nxt = 1'b0;
          end
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
          if (cnt == act_hm1) clk_out_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A write on a boundary edge lands in the pending register for the next boundary.
    if (div_wr) begin
      pend_mode_nxt   = div_mode;
      pend_val_nxt    = div_val;
      cfg_pending_nxt = 1'b1;
    end

    running_nxt = (state_nxt == ST_RUN);
  end

endmodule
